lane_deskew_rx: RTL and testbench
=================================

// Module: lane_deskew_rx
// PURPOSE
//  Multi-lane receive deskew stage, directly downstream of the per-lane alignment-marker lock stages.
//  Each lane buffers blocks from its own alignment marker (AM) onward in a small FIFO.
//  All lanes are then popped in lockstep, so block_o carries one time-aligned block per lane.
//  Alignment is rechecked at every subsequent AM; loss of alignment or lock triggers a flush and re-deskew.
// PARAMETERS
//  BLOCK_W  66  width of one 64b/66b block
//  LANE_N   4   number of physical lanes
//  DEPTH    8   per-lane FIFO entries; maximum tolerated skew is DEPTH-1 blocks
// PORTS
//  clk          in   1               clock
//  nreset       in   1               reset, asynchronous assert, active-low
//  valid_i      in   1               shared gearbox block strobe, common to all lanes
//  block_i      in   LANE_N*BLOCK_W  lane k at [k*BLOCK_W +: BLOCK_W]
//  am_v_i       in   LANE_N          per-lane AM match (lite am valid)
//  lock_v_i     in   LANE_N          per-lane AM lock (lite lock valid)
//  lane_i       in   LANE_N*LANE_N   per-lane one-hot logical lane id; used only with LANE_REORDER_EN
//  valid_o      out  1               aligned block strobe
//  block_o      out  LANE_N*BLOCK_W  aligned blocks
//  deskew_v_o   out  1               deskew achieved (state ALIGNED)
//  skew_err_o   out  1               1-cycle pulse: skew > DEPTH-1, or AM misalignment detected
// BEHAVIOUR
//  Reset: FSM=UNLOCK; FIFOs empty; valid_o=0, deskew_v_o=0, skew_err_o=0, block_o=0.
//  FIFO entry = {am_flag, block}, BLOCK_W+1 bits.
//  Writes and pops occur only on valid_i cycles.
//  FSM states:
//   UNLOCK: FIFOs flushed. -> WAIT_AM when &lock_v_i.
//   WAIT_AM: per lane, am_seen[k] sets on valid_i & am_v_i[k].
//     Lane k writes on valid_i & (am_seen[k] | am_v_i[k]); blocks before its AM are dropped.
//     Last AM written at cycle t (all am_seen) -> ALIGNED at t+1.
//     Any lane FIFO full while ~&am_seen -> skew_err_o pulse, flush, clear am_seen, stay WAIT_AM.
//     A full FIFO is never written.
//   ALIGNED: deskew_v_o=1. Each valid_i pops all lanes and writes all lanes, so occupancy stays constant.
//     Popped words register into block_o; valid_o=1 the cycle after the pop (latency 1).
//     Popped am_flag vector must be all-0 or all-1. Mixed -> skew_err_o, flush, -> WAIT_AM, valid_o=0 next cycle.
//  Any state: any lock_v_i low -> UNLOCK next cycle. FIFOs flush; deskew_v_o and valid_o drop the same edge.
//  Same-cycle AM on all lanes = zero skew: 1 entry per FIFO, ALIGNED next cycle.
//  Flush and pop in the same cycle: flush wins, no valid_o.
//  FIFO pointers are log2(DEPTH) bits, wrap naturally; DEPTH must be a power of 2.
//  The count has one extra bit to separate full from empty.
// CONFIGURATION
//  LANE_REORDER_EN defined:
//   Output slot j carries the physical lane k with lane_i[k*LANE_N+j]=1, latched on entry to ALIGNED.
//   Non-one-hot or duplicate ids -> skew_err_o and WAIT_AM.
//  LANE_REORDER_EN undefined:
//   Slot j = physical lane j; lane_i unused (lint waived).
// STRUCTURE
//  deskew_pkg: state enum {UNLOCK, WAIT_AM, ALIGNED}; default BLOCK_W/LANE_N.
//  Sub-module lane_fifo_rx: single-clock FIFO with wr/rd/flush, full/empty/count.
//   Instantiated LANE_N times via generate.
//  Top holds the FSM, am_seen, the am_flag consistency check and the optional reorder mux.
// TESTING
//  1 Zero skew: AM on all 4 lanes at the same valid_i.
//    -> deskew_v_o next cycle; first valid_o carries all four AMs in the same beat.
//  2 Skew 3: lane2 AM 3 valid cycles after lanes 0,1,3.
//    -> FIFOs 0,1,3 hold 4 entries, FIFO2 holds 1; output beats line up AM-to-AM.
//  3 Skew 8 with DEPTH=8: lane0 FIFO reaches 8 entries before lane3 AM.
//    -> skew_err_o pulse, flush, remain WAIT_AM, no valid_o.
//  4 In ALIGNED, inject a lane1 AM one block early at the next AM period.
//    -> mixed am_flag on pop -> skew_err_o, deskew_v_o=0, WAIT_AM.
//  5 Drop lock_v_i[3] for 1 cycle mid-stream.
//    -> UNLOCK, flush; re-deskew after the next AM set. Also assert nreset mid-ALIGNED: outputs 0 immediately.
//  6 LANE_REORDER_EN, lane_i maps physical 0..3 to logical 3,2,1,0.
//    -> block_o slot0 carries physical lane3 data.

Source files
------------

// File: rtl/deskew_pkg.sv
// Shared types and default sizes for the multi-lane receive deskew stage.
package deskew_pkg;

    localparam int unsigned BLOCK_W_DEF = 66;
    localparam int unsigned LANE_N_DEF  = 4;
    localparam int unsigned DEPTH_DEF   = 8;

    typedef enum logic [1:0] {
        UNLOCK  = 2'd0,
        WAIT_AM = 2'd1,
        ALIGNED = 2'd2
    } state_e;

endpackage

// File: rtl/lane_fifo_rx.sv
// Single-clock per-lane deskew FIFO with synchronous flush; head word is visible combinationally.
module lane_fifo_rx
    import deskew_pkg::*;
#(
    parameter int unsigned WIDTH = BLOCK_W_DEF + 1,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     flush,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rdata_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    assign rdata_c = mem[rptr];

    // A full FIFO accepts a write only when the same cycle pops it.
    assign rd_ok = rd & ~flush & ~empty_c;
    assign wr_ok = wr & ~flush & (~full_c | rd_ok);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + PW'(1);
            if (rd_ok) rptr <= rptr + PW'(1);
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/lane_deskew_rx.sv
// Multi-lane deskew: buffers each lane from its AM onward and pops all lanes in lockstep.
// Optional LANE_REORDER_EN maps physical lanes onto logical output slots via lane_i.
module lane_deskew_rx
    import deskew_pkg::*;
#(
    parameter int unsigned BLOCK_W = BLOCK_W_DEF,
    parameter int unsigned LANE_N  = LANE_N_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        valid_i,
    input  logic [LANE_N*BLOCK_W-1:0]   block_i,
    input  logic [LANE_N-1:0]           am_v_i,
    input  logic [LANE_N-1:0]           lock_v_i,
    input  logic [LANE_N*LANE_N-1:0]    lane_i,
    output logic                        valid_o,
    output logic [LANE_N*BLOCK_W-1:0]   block_o,
    output logic                        deskew_v_o,
    output logic                        skew_err_o
);

    localparam int unsigned EW = BLOCK_W + 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_e                    state;
    state_e                    state_nxt;
    logic [LANE_N-1:0]         am_seen;
    logic [LANE_N-1:0]         am_seen_nxt;
    logic [LANE_N-1:0]         wr;
    logic [LANE_N-1:0]         full;
    logic [LANE_N-1:0]         empty;
    logic [LANE_N-1:0]         head_am;
    logic                      flush;
    logic                      rd_all;
    logic                      err_c;
    logic                      map_ok_c;
    logic [EW-1:0]             head [LANE_N];
    logic [CW-1:0]             lvl  [LANE_N];
    logic [LANE_N*BLOCK_W-1:0] out_c;
    logic                      unused_lvl;

    // One FIFO per physical lane; entry is {am_flag, block}.
    for (genvar k = 0; k < LANE_N; k++) begin : g_lane
        lane_fifo_rx #(
            .WIDTH (EW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .nreset  (nreset),
            .flush   (flush),
            .wr      (wr[k]),
            .wdata   ({am_v_i[k], block_i[k*BLOCK_W +: BLOCK_W]}),
            .rd      (rd_all),
            .rdata_c (head[k]),
            .full_c  (full[k]),
            .empty_c (empty[k]),
            .count   (lvl[k])
        );
        assign head_am[k] = head[k][BLOCK_W];
    end

    always_comb begin
        unused_lvl = 1'b0;
        for (int k = 0; k < LANE_N; k++) unused_lvl = unused_lvl ^ (^lvl[k]);
    end

`ifdef LANE_REORDER_EN
    logic [LANE_N*LANE_N-1:0] map_q;
    logic                     enter_c;

    // Ids are valid only if each lane is one-hot and together they cover every slot.
    always_comb begin
        logic [LANE_N-1:0] cover;
        cover    = '0;
        map_ok_c = 1'b1;
        for (int k = 0; k < LANE_N; k++) begin
            if (!$onehot(lane_i[k*LANE_N +: LANE_N])) map_ok_c = 1'b0;
            cover = cover | lane_i[k*LANE_N +: LANE_N];
        end
        if (cover != '1) map_ok_c = 1'b0;
    end

    assign enter_c = (state != ALIGNED) && (state_nxt == ALIGNED);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)      map_q <= '0;
        else if (enter_c) map_q <= lane_i;
    end

    always_comb begin
        out_c = '0;
        for (int j = 0; j < LANE_N; j++) begin
            for (int k = 0; k < LANE_N; k++) begin
                if (map_q[k*LANE_N + j]) out_c[j*BLOCK_W +: BLOCK_W] = head[k][BLOCK_W-1:0];
            end
        end
    end
`else
    logic unused_lane_id;

    assign map_ok_c       = 1'b1;
    assign unused_lane_id = ^lane_i;

    always_comb begin
        out_c = '0;
        for (int j = 0; j < LANE_N; j++) out_c[j*BLOCK_W +: BLOCK_W] = head[j][BLOCK_W-1:0];
    end
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= UNLOCK;
            am_seen <= '0;
        end else begin
            state   <= state_nxt;
            am_seen <= am_seen_nxt;
        end
    end

    // Lock loss overrides everything; flush always wins over a pending pop or write.
    always_comb begin
        state_nxt   = state;
        am_seen_nxt = am_seen;
        flush       = 1'b0;
        wr          = '0;
        rd_all      = 1'b0;
        err_c       = 1'b0;
        if (!(&lock_v_i)) begin
            state_nxt   = UNLOCK;
            flush       = 1'b1;
            am_seen_nxt = '0;
        end else begin
            case (state)
                UNLOCK: begin
                    flush       = 1'b1;
                    am_seen_nxt = '0;
                    state_nxt   = WAIT_AM;
                end
                WAIT_AM: begin
                    if ((|full) && !(&am_seen)) begin
                        err_c       = 1'b1;
                        flush       = 1'b1;
                        am_seen_nxt = '0;
                    end else if (valid_i) begin
                        am_seen_nxt = am_seen | am_v_i;
                        wr          = am_seen_nxt & ~full;
                        if (&am_seen_nxt) begin
                            if (map_ok_c) begin
                                state_nxt = ALIGNED;
                            end else begin
                                err_c       = 1'b1;
                                flush       = 1'b1;
                                wr          = '0;
                                am_seen_nxt = '0;
                            end
                        end
                    end
                end
                ALIGNED: begin
                    if (valid_i) begin
                        if ((|head_am) && !(&head_am)) begin
                            err_c       = 1'b1;
                            flush       = 1'b1;
                            am_seen_nxt = '0;
                            state_nxt   = WAIT_AM;
                        end else if (!(|empty)) begin
                            rd_all = 1'b1;
                            wr     = '1;
                        end
                    end
                end
                default: begin
                    state_nxt = UNLOCK;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_o    <= 1'b0;
            deskew_v_o <= 1'b0;
            skew_err_o <= 1'b0;
            block_o    <= '0;
        end else begin
            valid_o    <= rd_all;
            deskew_v_o <= (state_nxt == ALIGNED);
            skew_err_o <= err_c;
            if (rd_all) block_o <= out_c;
        end
    end

endmodule

// File: tb/tb_lane_deskew_rx.sv
// Randomized bench for lane_deskew_rx against a queue-based reference model of the deskew rules.
module tb_lane_deskew_rx;

    localparam int unsigned BW = 66;
    localparam int unsigned N  = 4;
    localparam int unsigned D  = 8;
    localparam int unsigned EW = BW + 1;
    localparam int          P  = 16;
    localparam int M_UNLOCK = 0, M_WAIT = 1, M_ALIGNED = 2;

    logic            clk = 1'b0;
    logic            nreset;
    logic            valid;
    logic [N*BW-1:0] block;
    logic [N-1:0]    am;
    logic [N-1:0]    lock;
    logic [N*N-1:0]  lane_id;
    logic            valid_o;
    logic [N*BW-1:0] block_o;
    logic            deskew_v_o;
    logic            skew_err_o;

    lane_deskew_rx #(.BLOCK_W(BW), .LANE_N(N), .DEPTH(D)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .valid_i    (valid),
        .block_i    (block),
        .am_v_i     (am),
        .lock_v_i   (lock),
        .lane_i     (lane_id),
        .valid_o    (valid_o),
        .block_o    (block_o),
        .deskew_v_o (deskew_v_o),
        .skew_err_o (skew_err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [N*BW-1:0] got, input logic [N*BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stimulus generator state: lane k emits an AM every P valid blocks, offset by off[k].
    int          vc = 0;
    int          inj_vc = -1;
    int          dens = 4;
    int          off [N];
    logic [N-1:0] drop = '0;

    // Reference model: one queue per lane plus a deskew mode.
    logic [EW-1:0] mq [N][$];
    int            mmode;
    int            mmap [N];
    bit            mseen [N];
    bit            e_valid, e_dv, e_err;
    logic [N*BW-1:0] e_blk;

    int ob_v, ob_e;
    bit fresh = 1'b1;

    function automatic bit is_am(input int k, input int v);
        if (k == 1 && inj_vc > 0) begin
            if (v == inj_vc - 1) return 1'b1;
            if (v == inj_vc)     return 1'b0;
        end
        return (v >= off[k]) && (((v - off[k]) % P) == 0);
    endfunction

    function automatic int tag_lane(input logic [BW-1:0] b);
        logic [31:0] t;
        if (b[BW-1 -: 2] != 2'b10) return -1;
        t = b[63:32] - 32'h4D41_4B00;
        return int'(t);
    endfunction

    task automatic gen_inputs();
        valid = ($urandom_range(0, 3) < dens);
        for (int k = 0; k < N; k++) begin
            am[k] = valid && is_am(k, vc);
            if (am[k]) block[k*BW +: BW] = {2'b10, 32'h4D41_4B00 + 32'(k), 32'($urandom)};
            else       block[k*BW +: BW] = {2'b01, 32'($urandom), 32'($urandom)};
        end
        if (valid) vc++;
        lock = ~drop;
    endtask

    task automatic mflush();
        for (int k = 0; k < N; k++) begin
            mq[k].delete();
            mseen[k] = 1'b0;
        end
    endtask

    function automatic bit map_ids();
        bit          ok;
        logic [N-1:0] covered;
        logic [N-1:0] id;
        ok = 1'b1;
        covered = '0;
        for (int j = 0; j < N; j++) mmap[j] = j;
`ifdef LANE_REORDER_EN
        for (int k = 0; k < N; k++) begin
            id = lane_id[k*N +: N];
            if ($countones(id) != 1) ok = 1'b0;
            for (int j = 0; j < N; j++) if (id[j]) begin mmap[j] = k; covered[j] = 1'b1; end
        end
        if (covered != '1) ok = 1'b0;
`else
        id = '0;
        covered = id;
`endif
        return ok;
    endfunction

    task automatic model_step();
        bit anyfull, allseen;
        int n;
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (lock != '1) begin
            mflush();
            mmode = M_UNLOCK;
        end else if (mmode == M_UNLOCK) begin
            mflush();
            mmode = M_WAIT;
        end else if (mmode == M_WAIT) begin
            anyfull = 1'b0;
            allseen = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (mq[k].size() >= D) anyfull = 1'b1;
                if (!mseen[k]) allseen = 1'b0;
            end
            if (anyfull && !allseen) begin
                e_err = 1'b1;
                mflush();
            end else if (valid) begin
                allseen = 1'b1;
                for (int k = 0; k < N; k++) begin
                    if (am[k]) mseen[k] = 1'b1;
                    if (mseen[k] && mq[k].size() < D) mq[k].push_back({am[k], block[k*BW +: BW]});
                    if (!mseen[k]) allseen = 1'b0;
                end
                if (allseen) begin
                    if (map_ids()) mmode = M_ALIGNED;
                    else begin e_err = 1'b1; mflush(); end
                end
            end
        end else if (valid) begin
            n = 0;
            for (int k = 0; k < N; k++) n += int'(mq[k][0][BW]);
            if (n != 0 && n != N) begin
                e_err = 1'b1;
                mflush();
                mmode = M_WAIT;
            end else begin
                for (int j = 0; j < N; j++) e_blk[j*BW +: BW] = mq[mmap[j]][0][BW-1:0];
                for (int k = 0; k < N; k++) begin
                    void'(mq[k].pop_front());
                    mq[k].push_back({am[k], block[k*BW +: BW]});
                end
                e_valid = 1'b1;
            end
        end
        e_dv = (mmode == M_ALIGNED);
    endtask

    // One clock: drive at negedge, model at posedge, compare 1 time unit later.
    task automatic cyc();
        int n;
        int exp_lane;
        gen_inputs();
        @(posedge clk);
        model_step();
        #1;
        chk("valid_o", valid_o, e_valid);
        chk("deskew_v_o", deskew_v_o, e_dv);
        chk("skew_err_o", skew_err_o, e_err);
        if (valid_o) begin
            ob_v++;
            if (e_valid) chk("block_o", block_o, e_blk);
            n = 0;
            for (int j = 0; j < N; j++) if (tag_lane(block_o[j*BW +: BW]) >= 0) n++;
            chk("am_beat", (n == 0 || n == N), 1);
            if (fresh) begin
                for (int j = 0; j < N; j++) begin
`ifdef LANE_REORDER_EN
                    exp_lane = N - 1 - j;
`else
                    exp_lane = j;
`endif
                    chk("first_slot_am", tag_lane(block_o[j*BW +: BW]), exp_lane);
                end
            end
            fresh = 1'b0;
        end
        if (!deskew_v_o) fresh = 1'b1;
        if (skew_err_o) ob_e++;
        @(negedge clk);
    endtask

    task automatic run(input int cycles);
        ob_v = 0;
        ob_e = 0;
        for (int i = 0; i < cycles; i++) cyc();
    endtask

    task automatic wait_aligned(input string tag);
        for (int i = 0; i < 300 && !deskew_v_o; i++) cyc();
        chk(tag, deskew_v_o, 1);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        nreset = 1'b0;
        #1;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_deskew_v_o", deskew_v_o, 0);
        chk("rst_skew_err_o", skew_err_o, 0);
        chk("rst_block_o", block_o, '0);
        mflush();
        mmode = M_UNLOCK;
        for (int j = 0; j < N; j++) mmap[j] = j;
        fresh = 1'b1;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic set_off(input int o0, input int o1, input int o2, input int o3);
        off[0] = o0; off[1] = o1; off[2] = o2; off[3] = o3;
    endtask

    initial begin
        valid   = 1'b0;
        block   = '0;
        am      = '0;
        lock    = '1;
        lane_id = '0;
        for (int k = 0; k < N; k++) lane_id[k*N + (N-1-k)] = 1'b1;
        set_off(0, 0, 0, 0);
        @(negedge clk);
        do_reset();

        // Zero skew: every lane sees its AM on the same valid block.
        dens = 4;
        run(60);
        chk("s1_valid_seen", ob_v > 0, 1);
        chk("s1_no_err", ob_e, 0);

        // Skew of 3 on lane 2.
        do_reset();
        set_off(0, 0, 3, 0);
        dens = 3;
        run(150);
        chk("s2_valid_seen", ob_v > 0, 1);
        chk("s2_deskewed", deskew_v_o, 1);

        // Skew of 8 exceeds DEPTH-1: never aligns, repeated errors.
        do_reset();
        set_off(0, 0, 0, 8);
        dens = 4;
        run(120);
        chk("s3_no_valid", ob_v, 0);
        chk("s3_err_seen", ob_e > 0, 1);
        chk("s3_not_deskewed", deskew_v_o, 0);

        // Early lane-1 AM while aligned forces a mixed AM pop.
        do_reset();
        set_off(0, 1, 0, 2);
        dens = 3;
        wait_aligned("s4_align_wait");
        inj_vc = (vc / P + 2) * P;
        run(90);
        chk("s4_err_seen", ob_e > 0, 1);
        run(120);
        chk("s4_realigned", deskew_v_o, 1);
        inj_vc = -1;

        // One-cycle lock drop on lane 3, then re-deskew, then reset while aligned.
        drop = 4'b1000;
        cyc();
        drop = '0;
        chk("s5_lock_dv", deskew_v_o, 0);
        chk("s5_lock_valid", valid_o, 0);
        wait_aligned("s5_realign");
        run(5);
        chk("s5_pre_rst_dv", deskew_v_o, 1);
        do_reset();

        // Random skews and strobe densities.
        for (int r = 0; r < 6; r++) begin
            set_off(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
            dens = int'($urandom_range(1, 4));
            run(150);
            if (r == 2) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
